epmp_ifetch: RTL and testbench

Instruction fetch sequencer for the EPMP core; the writer side of the instruction register load interface. On request it reads one byte from program memory at the program counter over a req/ack handshake. It drives the fetched byte onto IBL and pulses IR_Load for one cycle so the instruction register captures it. It owns the PC, with increment and jump-load, and flags memory timeouts.

---
 rtl/epmp_ifetch.sv | 105 ++++++++++
 tb/tb_epmp_ifetch.sv | 123 ++++++++++++
 2 files changed

// File: rtl/epmp_ifetch.sv
// Instruction fetch sequencer: reads one byte at PC over a req/ack handshake,
// presents it on IBL with a one-cycle IR_Load strobe, and owns the PC.
module epmp_ifetch #(
  parameter int          AW       = 8,
  parameter int          DW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int          TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_start,
  input  logic          pc_load,
  input  logic [AW-1:0] pc_in,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_din,
  output logic [DW-1:0] IBL,
  output logic          IR_Load,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          fetch_done,
  output logic          fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, LOAD} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [7:0]    cnt, cnt_nx;
  logic [AW-1:0] pc_nx, addr_nx;
  logic [DW-1:0] ibl_nx;
  logic          rd_nx, irl_nx, err_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = pc;
    addr_nx  = mem_addr;
    ibl_nx   = IBL;
    rd_nx    = mem_rd;
    irl_nx   = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pc_load) pc_nx = pc_in;
        if (fetch_start) begin
          addr_nx  = pc_load ? pc_in : pc;
          rd_nx    = 1'b1;
          cnt_nx   = '0;
          state_nx = REQ;
        end
      end
      REQ: begin
        // ack wins even on the last allowed cycle
        if (mem_rd && mem_ack) begin
          ibl_nx   = mem_din;
          rd_nx    = 1'b0;
          state_nx = LOAD;
        end else if (cnt == TO_LAST) begin
          rd_nx    = 1'b0;
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      LOAD: begin
        irl_nx   = 1'b1;
        pc_nx    = pc + AW'(1);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // busy is registered, so it tracks the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pc         <= RESET_PC;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      IBL        <= '0;
      IR_Load    <= 1'b0;
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      pc         <= pc_nx;
      mem_addr   <= addr_nx;
      mem_rd     <= rd_nx;
      IBL        <= ibl_nx;
      IR_Load    <= irl_nx;
      fetch_done <= irl_nx;
      fetch_err  <= err_nx;
      busy       <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_epmp_ifetch.sv
// Randomized bench for epmp_ifetch against a transaction-level fetch model.
module tb_epmp_ifetch;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst, fetch_start, pc_load, mem_ack;
  logic [7:0] pc_in, mem_din;
  logic       mem_rd, IR_Load, busy, fetch_done, fetch_err;
  logic [7:0] mem_addr, IBL, pc;

  epmp_ifetch #(.AW(8), .DW(8), .RESET_PC(8'h00), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_load(pc_load),
    .pc_in(pc_in), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_din(mem_din), .IBL(IBL), .IR_Load(IR_Load), .pc(pc), .busy(busy),
    .fetch_done(fetch_done), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_err = 0;
  logic [7:0] mem [256];
  logic [7:0] pc_m, ibl_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One fetch: ack arrives in the d-th (0-based) cycle of mem_rd; d>=TIMEOUT never acks.
  task automatic fetch(input bit ld, input logic [7:0] tgt, input int d, input bit poke);
    logic [7:0] ea;
    bit ok;
    int rd_cyc, irl, err, ir_at, err_at;
    ok = (d < TIMEOUT);
    ea = ld ? tgt : pc_m;
    if (ld) pc_m = tgt;
    @(negedge clk);
    fetch_start = 1'b1; pc_load = ld; pc_in = tgt;
    @(negedge clk);
    fetch_start = 1'b0; pc_load = 1'b0;
    chk("busy_req", busy, 1);
    rd_cyc = 0; irl = 0; err = 0; ir_at = -1; err_at = -1;
    for (int i = 0; i < TIMEOUT + 6; i++) begin
      if (mem_rd) begin
        rd_cyc++;
        if (mem_addr !== ea) chk("mem_addr", mem_addr, ea);
      end
      if (IR_Load) begin
        irl++; ir_at = i;
        chk("ibl_at_load", IBL, mem[ea]);
        chk("fetch_done", fetch_done, 1);
      end
      if (fetch_err) begin err++; err_at = i; end
      // stray acks while mem_rd is low must be ignored
      if (mem_rd) mem_ack = (rd_cyc - 1 == d);
      else        mem_ack = 1'($urandom_range(0, 1));
      mem_din = mem_ack && mem_rd ? mem[mem_addr] : 8'($urandom);
      if (poke && i == 1) begin fetch_start = 1'b1; pc_load = 1'b1; pc_in = 8'h40; end
      if (i == 2) begin fetch_start = 1'b0; pc_load = 1'b0; end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk("rd_cycles", rd_cyc, ok ? d + 1 : TIMEOUT);
    chk("ir_loads", irl, ok ? 1 : 0);
    chk("errs", err, ok ? 0 : 1);
    if (ok) chk("ir_latency", ir_at, d + 2);
    else    chk("err_latency", err_at, TIMEOUT);
    if (ok) begin pc_m = ea + 8'd1; ibl_m = mem[ea]; end
    chk("pc", pc, pc_m);
    chk("ibl", IBL, ibl_m);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    mem[0] = 8'h3C; mem[1] = 8'hA5;
    rst = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_in = '0; mem_ack = 1'b0; mem_din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_pc", pc, 0);
    chk("rst_outs", {mem_rd, IR_Load, busy, fetch_done, fetch_err}, 0);
    chk("rst_ibl", IBL, 0);
    chk("rst_addr", mem_addr, 0);
    pc_m = 8'h00; ibl_m = 8'h00;

    fetch(0, 8'h00, 0, 0);     // 0x3C, zero wait
    fetch(0, 8'h00, 3, 0);     // 0xA5, 3 wait states
    fetch(1, 8'hFF, 0, 0);     // jump to 0xFF, pc wraps
    fetch(0, 8'h00, 1, 0);     // reads 0x00 after wrap
    fetch(0, 8'h00, 1000, 0);  // timeout
    fetch(0, 8'h00, TIMEOUT - 1, 0); // ack on last cycle
    fetch(0, 8'h00, 2, 1);     // ignored requests during REQ
    fetch(0, 8'h00, 0, 1);     // ignored requests during LOAD

    // reset in the middle of a request
    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    chk("pre_rst_rd", mem_rd, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_rd", mem_rd, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_ibl", IBL, 0);
    chk("mid_rst_pulses", {IR_Load, fetch_err, busy}, 0);
    pc_m = 8'h00; ibl_m = 8'h00;
    fetch(0, 8'h00, 0, 0);

    for (int k = 0; k < 30; k++)
      fetch(1'($urandom_range(0, 3) == 0), 8'($urandom),
            ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, TIMEOUT - 1)),
            1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
